// File: rtl/exception_cause_unit.sv
// Exception cause unit: masks and latches N_SRC sticky exception requests and
// picks the lowest pending index. It captures the cause and EPC, then offers the
// exception to control and blocks nesting until eret.
// Latency: request->pending 1 edge, pending->exc_pending 1 edge; drops are counted with saturation.
module exception_cause_unit #(
  parameter int N_SRC  = 8,
  parameter int CODE_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  exc_req,
  input  logic [N_SRC-1:0]  exc_mask,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              handler_ack,
  input  logic              eret,
  input  logic              er_write,
  input  logic [CODE_W-1:0] er_i,
  input  logic              clr_drop,
  output logic              exc_pending,
  output logic              in_handler,
  output logic [CODE_W-1:0] cause_o,
  output logic [PC_W-1:0]   epc_o,
  output logic [N_SRC-1:0]  pending_o,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PW = $clog2(N_SRC + 1);
  localparam int SW = CNT_W + PW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HANDLER = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_exc_pending;
  logic                r_in_handler;
  logic [CODE_W-1:0]   r_cause;
  logic [PC_W-1:0]     r_epc;
  logic [N_SRC-1:0]    r_pending;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic [N_SRC-1:0]    w_set;
  logic [N_SRC-1:0]    w_clr;
  logic [N_SRC-1:0]    w_drop;
  logic [CODE_W-1:0]   w_sel;
  logic                w_capture;
  logic [PW-1:0]       w_drop_n;
  logic [SW-1:0]       w_cnt_sum;
  logic [CNT_W-1:0]    w_cnt_next;

  // Unmasked requests that may set pending this edge
  assign w_set = exc_req & ~exc_mask;

  // A capture happens whenever the unit is idle and anything is pending
  assign w_capture = (r_state == S_IDLE) && (r_pending != '0);

  // Lowest-index pending source, from registered pending only
  always_comb begin
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel = CODE_W'(i);
    end
  end

  // One-hot clear of the captured source; a simultaneous set re-asserts it
  always_comb begin
    w_clr = '0;
    if (w_capture) w_clr[w_sel] = 1'b1;
  end

  // A drop is a new request on a bit that is already pending and not being consumed
  assign w_drop = w_set & r_pending & ~w_clr;

  // Population count of dropped bits and saturating next counter value
  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_drop_n = w_drop_n + {{(PW-1){1'b0}}, w_drop[i]};
    end
    w_cnt_sum = {{PW{1'b0}}, r_drop_cnt} + {{CNT_W{1'b0}}, w_drop_n};
    if (w_cnt_sum > {{PW{1'b0}}, {CNT_W{1'b1}}}) begin
      w_cnt_next = {CNT_W{1'b1}};
    end else begin
      w_cnt_next = w_cnt_sum[CNT_W-1:0];
    end
  end

  // Sticky pending bits: set wins over the capture clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  // Dropped-request counter; clear wins over increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (clr_drop) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_cnt_next;
    end
  end

  // Handshake FSM with registered status outputs, cause and EPC capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_exc_pending <= 1'b0;
      r_in_handler  <= 1'b0;
      r_cause       <= '0;
      r_epc         <= '0;
    end else begin
      // Software write first so that a capture on the same edge overrides it
      if (er_write) r_cause <= er_i;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_cause       <= w_sel;
            r_epc         <= pc_i;
            r_state       <= S_REQ;
            r_exc_pending <= 1'b1;
          end
        end
        S_REQ: begin
          if (handler_ack) begin
            r_state       <= S_HANDLER;
            r_exc_pending <= 1'b0;
            r_in_handler  <= 1'b1;
          end
        end
        S_HANDLER: begin
          if (eret) begin
            r_state      <= S_IDLE;
            r_in_handler <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_exc_pending <= 1'b0;
          r_in_handler  <= 1'b0;
        end
      endcase
    end
  end

  assign exc_pending = r_exc_pending;
  assign in_handler  = r_in_handler;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign pending_o   = r_pending;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_exception_cause_unit.sv
// Directed testbench for exception_cause_unit (default parameters).
module tb_exception_cause_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  exc_req;
  logic [7:0]  exc_mask;
  logic [31:0] pc_i;
  logic        handler_ack;
  logic        eret;
  logic        er_write;
  logic [4:0]  er_i;
  logic        clr_drop;
  logic        exc_pending;
  logic        in_handler;
  logic [4:0]  cause_o;
  logic [31:0] epc_o;
  logic [7:0]  pending_o;
  logic [3:0]  drop_cnt;

  int tests;
  int fails;

  exception_cause_unit dut (
    .clk        (clk),
    .reset      (reset),
    .exc_req    (exc_req),
    .exc_mask   (exc_mask),
    .pc_i       (pc_i),
    .handler_ack(handler_ack),
    .eret       (eret),
    .er_write   (er_write),
    .er_i       (er_i),
    .clr_drop   (clr_drop),
    .exc_pending(exc_pending),
    .in_handler (in_handler),
    .cause_o    (cause_o),
    .epc_o      (epc_o),
    .pending_o  (pending_o),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic ep, input logic ih);
    check({tag, ".exc_pending"}, {31'd0, exc_pending}, {31'd0, ep});
    check({tag, ".in_handler"},  {31'd0, in_handler},  {31'd0, ih});
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; exc_req = '0; exc_mask = '0; pc_i = '0;
    handler_ack = 1'b0; eret = 1'b0; er_write = 1'b0; er_i = '0; clr_drop = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_state("rst", 1'b0, 1'b0);
    check("rst.pending", {24'd0, pending_o}, 32'h0);
    check("rst.cause",   {27'd0, cause_o},   32'h0);
    check("rst.epc",     epc_o,              32'h0);
    check("rst.drop",    {28'd0, drop_cnt},  32'h0);

    // Single source 3
    exc_req = 8'h08; pc_i = 32'h0040_0010;
    tick();
    check("s1.pending", {24'd0, pending_o}, 32'h08);
    check_state("s1.a", 1'b0, 1'b0);
    exc_req = 8'h00;
    tick();
    check_state("s1.b", 1'b1, 1'b0);
    check("s1.cause",    {27'd0, cause_o},   32'd3);
    check("s1.epc",      epc_o,              32'h0040_0010);
    check("s1.pend0",    {24'd0, pending_o}, 32'h0);
    eret = 1'b1; pc_i = 32'h0000_0444;
    tick();
    check_state("s1.eret_in_req", 1'b1, 1'b0);
    check("s1.epc_hold", epc_o, 32'h0040_0010);
    eret = 1'b0; handler_ack = 1'b1;
    tick();
    check_state("s1.ack", 1'b0, 1'b1);
    handler_ack = 1'b0; eret = 1'b1;
    tick();
    check_state("s1.eret", 1'b0, 1'b0);
    eret = 1'b0;

    // Priority: sources 2 and 5 together
    exc_req = 8'h24; pc_i = 32'h0000_0100;
    tick();
    check("pr.pending", {24'd0, pending_o}, 32'h24);
    exc_req = 8'h00;
    tick();
    check("pr.cause2",  {27'd0, cause_o},   32'd2);
    check("pr.pend20",  {24'd0, pending_o}, 32'h20);
    handler_ack = 1'b1;
    tick();
    handler_ack = 1'b0; eret = 1'b1;
    tick();
    check_state("pr.idle", 1'b0, 1'b0);
    check("pr.pend_idle", {24'd0, pending_o}, 32'h20);
    eret = 1'b0;
    tick();
    check_state("pr.req5", 1'b1, 1'b0);
    check("pr.cause5",  {27'd0, cause_o},   32'd5);
    check("pr.pend_clr", {24'd0, pending_o}, 32'h0);
    handler_ack = 1'b1; tick();
    handler_ack = 1'b0; eret = 1'b1; tick();
    eret = 1'b0;

    // Masking
    exc_mask = 8'h01; exc_req = 8'h01;
    tick();
    check("mk.pending", {24'd0, pending_o}, 32'h0);
    tick();
    check_state("mk.none", 1'b0, 1'b0);
    exc_mask = 8'h00;
    tick();
    check("mk.set0", {24'd0, pending_o}, 32'h01);
    exc_mask = 8'h01; exc_req = 8'h00;
    tick();
    check_state("mk.cap", 1'b1, 1'b0);
    check("mk.cause0", {27'd0, cause_o}, 32'd0);
    handler_ack = 1'b1; tick();
    handler_ack = 1'b0; eret = 1'b1; tick();
    eret = 1'b0; exc_mask = 8'h00;

    // Drops and saturation while in HANDLER
    exc_req = 8'h02; pc_i = 32'h0000_0200;
    tick();
    exc_req = 8'h00;
    tick();
    check("dr.cause1", {27'd0, cause_o}, 32'd1);
    handler_ack = 1'b1; tick();
    handler_ack = 1'b0;
    check_state("dr.hnd", 1'b0, 1'b1);
    exc_req = 8'h40;
    for (int i = 0; i < 20; i++) tick();
    check("dr.sat",     {28'd0, drop_cnt},  32'd15);
    check("dr.pending", {24'd0, pending_o}, 32'h40);
    check_state("dr.still_hnd", 1'b0, 1'b1);
    clr_drop = 1'b1;
    tick();
    check("dr.clr", {28'd0, drop_cnt}, 32'd0);
    clr_drop = 1'b0;
    tick();
    check("dr.one", {28'd0, drop_cnt}, 32'd1);
    exc_req = 8'h00;

    // Software write in HANDLER
    er_write = 1'b1; er_i = 5'h1F; pc_i = 32'h0000_0300;
    tick();
    check("sw.cause", {27'd0, cause_o}, 32'h1F);
    check("sw.epc",   epc_o,            32'h0000_0200);
    check_state("sw.hnd", 1'b0, 1'b1);
    er_write = 1'b0;
    eret = 1'b1; exc_req = 8'h02;
    tick();
    eret = 1'b0; exc_req = 8'h00;
    check("sw.pend42", {24'd0, pending_o}, 32'h42);
    check_state("sw.idle", 1'b0, 1'b0);
    er_write = 1'b1; er_i = 5'h1F;
    tick();
    er_write = 1'b0;
    check("sw.cap_wins", {27'd0, cause_o},   32'd1);
    check("sw.epc_cap",  epc_o,              32'h0000_0300);
    check("sw.pend40",   {24'd0, pending_o}, 32'h40);
    check("sw.drop",     {28'd0, drop_cnt},  32'd1);

    // Reset mid-REQ
    handler_ack = 1'b1; tick();
    handler_ack = 1'b0; eret = 1'b1; tick();
    eret = 1'b0; tick();
    check("rm.cause6", {27'd0, cause_o}, 32'd6);
    exc_req = 8'h10;
    tick();
    exc_req = 8'h00;
    check("rm.pend10", {24'd0, pending_o}, 32'h10);
    check_state("rm.req", 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_state("rm.rst", 1'b0, 1'b0);
    check("rm.pending", {24'd0, pending_o}, 32'h0);
    check("rm.cause",   {27'd0, cause_o},   32'h0);
    check("rm.epc",     epc_o,              32'h0);
    check("rm.drop",    {28'd0, drop_cnt},  32'h0);
    handler_ack = 1'b1;
    tick();
    handler_ack = 1'b0;
    check_state("rm.ack_ignored", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
